gumnut_data_arbiter: RTL and testbench

GUMNUT_DATA_ARBITER -- requirements
Module: gumnut_data_arbiter

---
 rtl/gumnut_arb_pkg.sv | 12 +
 rtl/arb_watchdog.sv | 28 ++
 rtl/gumnut_data_arbiter.sv | 130 +++++++++++++
 tb/tb_gumnut_data_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_arb_pkg.sv
// Shared types and constants for the gumnut two-master Wishbone data arbiter.
package gumnut_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/arb_watchdog.sv
// Stall watchdog: counts enabled cycles and pulses expire on the TIMEOUT-th one.
module arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [7:0] count;

  // Fires combinationally on the stalled cycle that would bring the count to TIMEOUT.
  assign expire = en & ~clr & (count == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (clr || expire) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/gumnut_data_arbiter.sv
// Two-master Wishbone arbiter for a shared slave: round-robin on ties, no
// preemption, one-cycle grant latency and a per-owner stall watchdog.
module gumnut_data_arbiter
  import gumnut_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  output logic [7:0] m0_dat_o,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic [7:0] m1_dat_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [7:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  output logic [1:0] gnt_o
);

  arb_state_e state;
  logic       last_m1;
  logic       own0, own1, active, own_stb;
  logic       release_c, grant_c, wd_en, wd_clr, expire;

  assign own0      = (state == OWN0);
  assign own1      = (state == OWN1);
  assign active    = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
  assign own_stb   = own0 ? m0_stb_i : m1_stb_i;
  assign release_c = (own0 & ~m0_cyc_i) | (own1 & ~m1_cyc_i);
  assign grant_c   = (state == IDLE) & (m0_cyc_i | m1_cyc_i);
  assign wd_en     = active & own_stb & ~s_ack_i;
  assign wd_clr    = ~wd_en | release_c | grant_c;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .en     (wd_en),
    .clr    (wd_clr),
    .expire (expire)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
      gnt_o   <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          // A tie goes to whichever master did not own the bus last.
          if (m0_cyc_i && (!m1_cyc_i || last_m1)) begin
            state <= OWN0;
            gnt_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= OWN1;
            gnt_o <= 2'b10;
          end
        end
        OWN0: if (!m0_cyc_i) begin
          state   <= IDLE;
          last_m1 <= 1'b0;
          gnt_o   <= 2'b00;
        end
        OWN1: if (!m1_cyc_i) begin
          state   <= IDLE;
          last_m1 <= 1'b1;
          gnt_o   <= 2'b00;
        end
        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
        end
      endcase
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (own0) begin
      m0_ack_o = s_ack_i;
      if (m0_cyc_i) begin
        s_cyc_o  = 1'b1;
        s_stb_o  = m0_stb_i & ~expire;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_err_o = expire;
      end
    end else if (own1) begin
      m1_ack_o = s_ack_i;
      if (m1_cyc_i) begin
        s_cyc_o  = 1'b1;
        s_stb_o  = m1_stb_i & ~expire;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_err_o = expire;
      end
    end
  end

endmodule

// File: tb/tb_gumnut_data_arbiter.sv
// Scoreboard bench: stimulus pushes the reference model's per-cycle response,
// a monitor pops and compares on each falling edge.
module tb_gumnut_data_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o, m0_err_o;
  logic [7:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic       m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o, m1_err_o;
  logic [7:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic       s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [7:0] s_adr_o, s_dat_o, s_dat_i;
  logic [1:0] gnt_o;

  always #5 clk_i = ~clk_i;

  gumnut_data_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  typedef struct packed {
    logic       c0, s0, w0;
    logic [7:0] a0, d0;
    logic       c1, s1, w1;
    logic [7:0] a1, d1;
    logic       ack;
    logic [7:0] sd;
  } stim_t;

  typedef struct packed {
    logic [1:0] gnt;
    logic       scyc, sstb, swe;
    logic [7:0] sadr, sdat;
    logic       ack0, err0, ack1, err1;
    logic [7:0] md0, md1;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference model: owner index (-1 idle), last owner, stalled-cycle count.
  int owner   = -1;
  int last    = 1;
  int stalled = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    m0_cyc_i = s.c0; m0_stb_i = s.s0; m0_we_i = s.w0; m0_adr_i = s.a0; m0_dat_i = s.d0;
    m1_cyc_i = s.c1; m1_stb_i = s.s1; m1_we_i = s.w1; m1_adr_i = s.a1; m1_dat_i = s.d1;
    s_ack_i  = s.ack; s_dat_i = s.sd;
  endtask

  // One cycle: drive inputs after the rising edge, predict this cycle's outputs.
  task automatic drive(input stim_t s, input logic rst);
    resp_t      e;
    logic [1:0] cyc, stb;
    bit         fire;
    int         n;
    @(posedge clk_i);
    #1;
    rst_i = rst;
    apply(s);
    e     = '0;
    e.md0 = s.sd;
    e.md1 = s.sd;
    cyc   = {s.c1, s.c0};
    stb   = {s.s1, s.s0};
    if (!rst) begin
      owner = -1; last = 1; stalled = 0;
    end else if (owner >= 0) begin
      n     = owner;
      e.gnt = 2'(1 << n);
      if (n == 0) e.ack0 = s.ack; else e.ack1 = s.ack;
      if (cyc[n]) begin
        fire   = stb[n] && !s.ack && (stalled + 1 == TIMEOUT);
        e.scyc = 1'b1;
        e.sstb = stb[n] && !fire;
        e.swe  = (n == 0) ? s.w0 : s.w1;
        e.sadr = (n == 0) ? s.a0 : s.a1;
        e.sdat = (n == 0) ? s.d0 : s.d1;
        if (n == 0) e.err0 = fire; else e.err1 = fire;
        if (stb[n] && !s.ack && !fire) stalled++;
        else stalled = 0;
      end else begin
        last = n; owner = -1; stalled = 0;
      end
    end else if (cyc != 2'b00) begin
      owner   = (cyc == 2'b11) ? 1 - last : (cyc[0] ? 0 : 1);
      stalled = 0;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt", 64'(gnt_o), 64'(e.gnt));
        check("slave_bus", 64'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}),
              64'({e.scyc, e.sstb, e.swe, e.sadr, e.sdat}));
        check("ack_err", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}),
              64'({e.ack0, e.err0, e.ack1, e.err1}));
        check("rdata", 64'({m0_dat_o, m1_dat_o}), 64'({e.md0, e.md1}));
      end
    end
  end

  initial begin : stimulus
    stim_t s, z;
    bit    no_ack;
    z = '0;
    rst_i = 1'b0;
    apply(z);

    drive(z, 1'b0);
    drive(z, 1'b0);
    #1 check("reset_gnt", 64'(gnt_o), 64'(2'b00));
    check("reset_scyc", 64'(s_cyc_o), 64'(1'b0));

    // Simultaneous requests straight out of reset: m0 wins.
    s = z;
    s.c0 = 1; s.s0 = 1; s.w0 = 1; s.a0 = 8'h10; s.d0 = 8'hA5;
    s.c1 = 1; s.s1 = 1; s.a1 = 8'h44; s.d1 = 8'h99;
    drive(s, 1'b1);
    #1 check("tie_idle_gnt", 64'(gnt_o), 64'(2'b00));
    s.ack = 1;
    drive(s, 1'b1);
    #1 check("tie_gnt", 64'(gnt_o), 64'(2'b01));
    check("m0_write_bus", 64'({s_we_o, s_adr_o, s_dat_o}), 64'({1'b1, 8'h10, 8'hA5}));
    check("m0_ack", 64'(m0_ack_o), 64'(1'b1));
    check("m1_ack_idle", 64'(m1_ack_o), 64'(1'b0));

    // m0 releases while m1 waits: one idle cycle, then m1 reads 3C.
    s.c0 = 0; s.s0 = 0; s.ack = 0; s.w1 = 0;
    drive(s, 1'b1);
    #1 check("release_scyc", 64'(s_cyc_o), 64'(1'b0));
    drive(s, 1'b1);
    #1 check("gap_gnt", 64'(gnt_o), 64'(2'b00));
    s.ack = 1; s.sd = 8'h3C;
    drive(s, 1'b1);
    #1 check("m1_gnt", 64'(gnt_o), 64'(2'b10));
    check("m1_read", 64'({m1_ack_o, m1_dat_o}), 64'({1'b1, 8'h3C}));
    drive(z, 1'b1);
    drive(z, 1'b1);

    // Six rounds of contention must alternate owners.
    for (int r = 0; r < 6; r++) begin
      s = z;
      s.c0 = 1; s.s0 = 1; s.c1 = 1; s.s1 = 1;
      drive(s, 1'b1);
      s.ack = 1;
      drive(s, 1'b1);
      #1 check("rr_gnt", 64'(gnt_o), 64'((r % 2 == 0) ? 2'b01 : 2'b10));
      drive(z, 1'b1);
      drive(z, 1'b1);
    end

    // Slave never acks: error pulse on every 15th stalled cycle.
    s = z;
    s.c0 = 1; s.s0 = 1; s.a0 = 8'h22;
    drive(s, 1'b1);
    for (int k = 1; k <= 2 * TIMEOUT; k++) begin
      drive(s, 1'b1);
      #1 check("wd_err", 64'(m0_err_o), 64'(k % TIMEOUT == 0));
      check("wd_stb", 64'(s_stb_o), 64'(k % TIMEOUT != 0));
    end
    drive(z, 1'b1);
    drive(z, 1'b1);

    // Ack landing on the timeout cycle wins over the error.
    drive(s, 1'b1);
    for (int k = 1; k < TIMEOUT; k++) drive(s, 1'b1);
    s.ack = 1;
    drive(s, 1'b1);
    #1 check("to_ack", 64'({m0_ack_o, m0_err_o}), 64'({1'b1, 1'b0}));
    s.ack = 0;
    drive(s, 1'b1);
    #1 check("to_cleared", 64'(m0_err_o), 64'(1'b0));
    drive(z, 1'b1);
    drive(z, 1'b1);

    // Asynchronous reset in the middle of an m1 transfer.
    s = z;
    s.c1 = 1; s.s1 = 1; s.w1 = 1; s.a1 = 8'h77; s.d1 = 8'h5A;
    drive(s, 1'b1);
    s.ack = 1;
    drive(s, 1'b1);
    #1 check("pre_rst_gnt", 64'(gnt_o), 64'(2'b10));
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1 check("async_rst_out", 64'({gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m1_ack_o, m1_err_o}), 64'(0));
    s.c0 = 1; s.s0 = 1; s.ack = 0;
    drive(s, 1'b0);
    drive(s, 1'b1);
    #1 check("post_rst_idle", 64'(gnt_o), 64'(2'b00));
    drive(s, 1'b1);
    #1 check("post_rst_gnt", 64'(gnt_o), 64'(2'b01));
    drive(z, 1'b1);
    drive(z, 1'b1);

    // Randomized traffic, with stretches of a dead slave to exercise timeouts.
    s = z;
    no_ack = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) no_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) s.c0 = ~s.c0;
      if ($urandom_range(0, 7) == 0) s.c1 = ~s.c1;
      s.s0  = no_ack ? 1'b1 : ($urandom_range(0, 3) != 0);
      s.s1  = no_ack ? 1'b1 : ($urandom_range(0, 3) != 0);
      s.w0  = 1'($urandom);
      s.w1  = 1'($urandom);
      s.a0  = 8'($urandom);
      s.d0  = 8'($urandom);
      s.a1  = 8'($urandom);
      s.d1  = 8'($urandom);
      s.ack = no_ack ? 1'b0 : ($urandom_range(0, 2) == 0);
      s.sd  = 8'($urandom);
      drive(s, 1'b1);
    end

    drive(z, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    #1 check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
